// File: rtl/daq_raw_framer.sv
// Raw-hit readout framer: reads a run of time bins from raw hit memory and
// serialises them into 19-bit DAQ words with zero suppression, padding and a trailer.
module daq_raw_framer #(
    parameter int NLY    = 6,
    parameter int NWG    = 48,
    parameter int ADDR_W = 8,
    parameter int ALIGN  = 4
) (
    input  logic                  clk,
    input  logic                  hard_rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     rd_base,
    input  logic [4:0]            tbins,
    input  logic                  zero_suppress,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [NLY*NWG-1:0]    mem_data,
    output logic [18:0]           daq_word,
    output logic                  daq_valid,
    input  logic                  daq_ready,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    localparam int NG = NWG / 12;
    localparam int LW = (NLY > 1) ? $clog2(NLY) : 1;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int AW = $clog2(ALIGN);
    localparam logic [18:0] W_BIN_ZERO   = 19'h02000;
    localparam logic [18:0] W_LAYER_ZERO = 19'h01000;
    localparam logic [18:0] W_PAD        = 19'h03000;
    localparam logic [7:0]  TRAIL_TAG    = 8'b00111010;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EMIT, S_PAD, S_TRAIL} state_t;

    // Handshake: a word moves on a clk edge with daq_valid=1 and daq_ready=1;
    // while daq_valid=1 and daq_ready=0 the word is held and nothing advances.
    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [4:0]           tbins_q, tbins_d;
    logic                 zs_q, zs_d;
    logic [4:0]           bin_q, bin_d;
    logic [LW-1:0]        layer_q, layer_d;
    logic [GW-1:0]        group_q, group_d;
    logic [10:0]          wcnt_q, wcnt_d;
    logic [NLY*NWG-1:0]   shadow_q, shadow_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [18:0]          word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    logic                 xfer;
    logic                 end_layer, end_bin, enter_tail;
    logic [NLY*NWG-1:0]   src;
    logic [11:0]          src_word [NLY][NG];
    logic [NLY-1:0]       lz;
    logic                 bz;

    assign xfer      = valid_q & daq_ready;
    assign mem_addr  = addr_q;
    assign daq_word  = word_q;
    assign daq_valid = valid_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

    function automatic logic [18:0] emit_word(input logic zs, input logic bin_zero,
                                              input logic layer_zero, input logic [11:0] w);
        if (zs && bin_zero)   return W_BIN_ZERO;
        if (zs && layer_zero) return W_LAYER_ZERO;
        return {7'b0, w};
    endfunction

    // In LOAD the first word comes straight from the memory bus; later words from the shadow.
    always_comb begin
        src = (state_q == S_LOAD) ? mem_data : shadow_q;
        bz  = ~|src;
        for (int l = 0; l < NLY; l++) begin
            lz[l] = ~|src[l*NWG +: NWG];
            for (int g = 0; g < NG; g++) begin
                src_word[l][g] = src[l*NWG + g*12 +: 12];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        tbins_d    = tbins_q;
        zs_d       = zs_q;
        bin_d      = bin_q;
        layer_d    = layer_q;
        group_d    = group_q;
        wcnt_d     = wcnt_q;
        shadow_d   = shadow_q;
        addr_d     = addr_q;
        word_d     = word_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        end_layer  = 1'b0;
        end_bin    = 1'b0;
        enter_tail = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = rd_base;
                    tbins_d = tbins;
                    zs_d    = zero_suppress;
                    bin_d   = '0;
                    wcnt_d  = '0;
                    if (tbins != 5'd0) begin
                        state_d = S_FETCH;
                        addr_d  = rd_base;
                    end else begin
                        enter_tail = 1'b1;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                state_d  = S_EMIT;
                shadow_d = mem_data;
                layer_d  = '0;
                group_d  = '0;
                word_d   = emit_word(zs_q, bz, lz[0], src_word[0][0]);
                valid_d  = 1'b1;
            end
            S_EMIT: begin
                if (xfer) begin
                    wcnt_d = wcnt_q + 11'd1;
                    if (zs_q && bz) begin
                        end_bin = 1'b1;
                    end else if ((zs_q && lz[layer_q]) || group_q == GW'(NG-1)) begin
                        end_layer = 1'b1;
                    end else begin
                        group_d = group_q + GW'(1);
                        word_d  = {7'b0, src_word[layer_q][group_d]};
                    end
                end
            end
            S_PAD: begin
                if (xfer) begin
                    wcnt_d     = wcnt_q + 11'd1;
                    enter_tail = 1'b1;
                end
            end
            S_TRAIL: begin
                if (xfer) begin
                    wcnt_d  = wcnt_q + 11'd1;
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    word_d  = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (end_layer) begin
            if (layer_q == LW'(NLY-1)) begin
                end_bin = 1'b1;
            end else begin
                layer_d = layer_q + LW'(1);
                group_d = '0;
                word_d  = emit_word(zs_q, bz, lz[layer_d], src_word[layer_d][0]);
            end
        end

        if (end_bin) begin
            bin_d = bin_q + 5'd1;
            if (bin_d == tbins_q) begin
                enter_tail = 1'b1;
            end else begin
                state_d = S_FETCH;
                addr_d  = base_q + ADDR_W'(bin_d);
                valid_d = 1'b0;
            end
        end

        // Pad until the count sits one short of the boundary, so the trailer lands on it.
        if (enter_tail) begin
            valid_d = 1'b1;
            if (wcnt_d[AW-1:0] == AW'(ALIGN-1)) begin
                state_d = S_TRAIL;
                word_d  = {TRAIL_TAG, wcnt_d + 11'd1};
            end else begin
                state_d = S_PAD;
                word_d  = W_PAD;
            end
        end
    end

    always_ff @(posedge clk or posedge hard_rst) begin
        if (hard_rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            tbins_q  <= '0;
            zs_q     <= 1'b0;
            bin_q    <= '0;
            layer_q  <= '0;
            group_q  <= '0;
            wcnt_q   <= '0;
            shadow_q <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            tbins_q  <= tbins_d;
            zs_q     <= zs_d;
            bin_q    <= bin_d;
            layer_q  <= layer_d;
            group_q  <= group_d;
            wcnt_q   <= wcnt_d;
            shadow_q <= shadow_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: doc/daq_raw_framer.md
Name: daq_raw_framer

Overview:
- Parametrised raw-hit readout framer for the ALCT DAQ path. It is the next generation of the raw-dump section of the DAQ formatter.
- On a start request it reads a run of time bins from the raw hit memory and serialises each bin into 19-bit DAQ words, with per-layer and per-bin zero suppression.
- It pads each frame to an alignment boundary and closes it with a word-count trailer.
- New over the previous generation: any layer count and wire-group width, ready/valid backpressure on the output, and a configurable frame alignment.

Parameters:
NLY, 6, number of layers per time bin
NWG, 48, wire groups per layer; must be a multiple of 12 (NG = NWG/12 words per layer)
ADDR_W, 8, raw memory address width
ALIGN, 4, frame length alignment in words; power of 2, at least 2

Ports:
clk  in  1  system clock
hard_rst  in  1  asynchronous, active-high reset
start  in  1  readout request; accepted only while busy=0
rd_base  in  ADDR_W  memory address of the first time bin
tbins  in  5  number of time bins to read (0..31)
zero_suppress  in  1  enables suppression of zero layers and zero bins
mem_addr  out  ADDR_W  raw memory read address
mem_data  in  NLY*NWG  raw memory read data; valid 1 clk after mem_addr; layer L occupies bits [L*NWG +: NWG]
daq_word  out  19  output DAQ word
daq_valid  out  1  daq_word is valid
daq_ready  in  1  downstream accepts daq_word
busy  out  1  readout in progress
done  out  1  one-clock pulse when the frame is complete

Behaviour:
- Reset (asynchronous, immediate, also mid-frame): state=IDLE; busy=0, done=0, daq_valid=0, daq_word=0, mem_addr=0; word counter=0. A partial frame is abandoned; no trailer is emitted.
- Transfer: a word transfers on a clk edge where daq_valid=1 and daq_ready=1. While daq_valid=1 and daq_ready=0, daq_word is held stable. All counters advance only on a transfer.
- Word counter: 11 bits; counts every transferred word, trailer included; wraps modulo 2048.
- start in IDLE:
  - latches rd_base, tbins and zero_suppress; clears bin and word counters; sets busy=1 on the next clk.
  - start while busy=1 is ignored.
- States:
  - IDLE: wait for start. Go to FETCH if tbins>0, otherwise go to PAD.
  - FETCH: drive mem_addr = base + bin (modulo 2^ADDR_W); daq_valid=0; go to LOAD.
  - LOAD: capture mem_data into the shadow register; compute bin_zero (all bits zero) and per-layer zero flags; layer=0, group=0; go to EMIT.
  - EMIT, when zero_suppress=1 and bin_zero: emit a single word 19'h02000, then advance to the next bin.
  - EMIT, when zero_suppress=1 and the layer is zero: emit a single word 19'h01000, then advance to the next layer.
  - EMIT, otherwise: emit NG words {7'b0, layer[12*g +: 12]} for g=0..NG-1, then advance to the next layer.
  - EMIT, after layer NLY-1: bin+1. If bin==tbins go to PAD, otherwise go to FETCH.
  - PAD: while (word counter mod ALIGN) != ALIGN-1, emit 19'h03000. Then go to TRAIL; no pad word is emitted if the counter is already at ALIGN-1.
  - TRAIL: emit {8'b00111010, word_count+1}, i.e. the total frame length including the trailer. On transfer go to IDLE and pulse done for 1 clk; busy=0 on that same edge.
- Per-bin gap: FETCH and LOAD cost 2 clk with daq_valid=0. A new start may be accepted on the clk after done.
- Output timing: daq_word is registered; daq_valid stays 0 outside EMIT, PAD and TRAIL.

Test Plan:
1. Defaults, zero_suppress=0, tbins=1, rd_base=0x10, layer 0 word 0 = 0xABC:
   - mem_addr=0x10.
   - 24 data words, the first 0x00ABC.
   - 3 words 0x03000.
   - trailer 0x1D01C; done pulses once.
2. zero_suppress=1, tbins=2, all-zero memory:
   - words 0x02000, 0x02000.
   - 1 pad word 0x03000.
   - trailer 0x1D004.
3. zero_suppress=1, tbins=1, only layer 2 bit 0 set:
   - 0x01000, 0x01000.
   - 0x00001 followed by 3 words 0x00000.
   - 3 words 0x01000.
   - 2 pad words.
   - trailer 0x1D00C.
4. tbins=0 -> 3 pad words then trailer 0x1D004; mem_addr never changes.
5. rd_base=0xFF, tbins=2 -> mem_addr 0xFF then 0x00 (wrap). Holding daq_ready=0 for 3 clk mid-layer -> daq_word constant, no word lost or duplicated, total still 52 words.
6. hard_rst asserted mid-EMIT -> busy, daq_valid and done are 0 immediately. start pulse while busy -> ignored; the frame content is unchanged.
